// File: rtl/db_scan_ctrl_pkg.sv
// Shared constants and types for the db_scan_ctrl switch debounce controller.
package db_pkg;

    localparam int DB_TICK_BITS    = 20;
    localparam int DB_STABLE_TICKS = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/db_scan_ctrl_if.sv
// Valid/ready debounced-event port of db_scan_ctrl; master = controller, slave = consumer.
interface db_evt_if #(
    parameter int N_CH = 4
);
    localparam int CH_W = $clog2(N_CH);

    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;
    logic            evt_rise;
    logic            evt_overrun;

    modport master (
        output evt_valid,
        output evt_ch,
        output evt_rise,
        output evt_overrun,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        input  evt_rise,
        input  evt_overrun,
        output evt_ready
    );

endinterface

// File: rtl/db_scan_ctrl_chan.sv
// One debounce channel: 2-flop synchroniser, tick-qualified stability counter and db flop.
module db_chan
    import db_pkg::*;
#(
    parameter int STABLE_TICKS = DB_STABLE_TICKS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_tick,
    input  logic i_sw,
    output logic o_db,
    output logic o_edge,
    output logic o_new
);

    localparam int CNT_W = $clog2(STABLE_TICKS + 1);

    logic             r_meta;
    logic             r_s;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;
    logic             w_mis;
    logic             w_flip;

    assign w_mis  = r_s ^ r_db;
    // Flip on the tick that would complete STABLE_TICKS mismatching ticks.
    assign w_flip = w_mis && i_tick && (r_cnt == CNT_W'(STABLE_TICKS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_s    <= 1'b0;
            r_db   <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_sw;
            r_s    <= r_meta;
            if (!w_mis) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_db  <= r_s;
                r_cnt <= '0;
            end else if (i_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_db   = r_db;
    assign o_edge = w_flip;
    assign o_new  = r_s;

endmodule

// File: rtl/db_scan_ctrl.sv
// Multi-channel debounce controller with round-robin event serialisation.
// Optional feature macro: DB_RELEASE_EVT_EN (release edges also produce events).
module db_scan_ctrl
    import db_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_BITS    = DB_TICK_BITS,
    parameter int STABLE_TICKS = DB_STABLE_TICKS
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db,
    db_evt_if.master        evt
);

    localparam int CH_W = $clog2(N_CH);

    logic [TICK_BITS-1:0] r_presc;
    logic                 w_tick;
    logic [N_CH-1:0]      w_edge;
    logic [N_CH-1:0]      w_new;
    logic [N_CH-1:0]      w_qual;
    logic [N_CH-1:0]      w_clr;
    logic [N_CH-1:0]      w_ovr_vec;
    logic [N_CH-1:0]      r_pend;
    logic                 r_ovr;
    slot_state_t          r_state;
    logic [CH_W-1:0]      r_rr;
    logic [CH_W-1:0]      r_ch;
    logic [CH_W-1:0]      w_gnt;
    logic                 w_any;
    logic                 w_hs;
    logic                 w_load;

    assign w_tick = &r_presc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        db_chan #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_chan (
            .clk    (clk),
            .reset_n(reset_n),
            .i_tick (w_tick),
            .i_sw   (sw[g]),
            .o_db   (db[g]),
            .o_edge (w_edge[g]),
            .o_new  (w_new[g])
        );
    end

`ifdef DB_RELEASE_EVT_EN
    assign w_qual = w_edge;
`else
    assign w_qual = w_edge & w_new;
`endif

    // Lowest offset from r_rr wins; later loop iterations are closer and overwrite.
    always_comb begin
        int v_idx;
        w_any = 1'b0;
        w_gnt = '0;
        v_idx = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            v_idx = int'(r_rr) + k;
            if (v_idx >= N_CH) v_idx = v_idx - N_CH;
            if (r_pend[v_idx]) begin
                w_any = 1'b1;
                w_gnt = CH_W'(v_idx);
            end
        end
    end

    assign w_hs   = (r_state == FULL) && evt.evt_ready;
    assign w_load = w_any && ((r_state == EMPTY) || w_hs);

    always_comb begin
        w_clr     = '0;
        w_ovr_vec = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_clr[i]     = w_load && (w_gnt == CH_W'(i));
            w_ovr_vec[i] = w_qual[i] && r_pend[i] && !w_clr[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
            r_ovr  <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_qual;
            r_ovr  <= |w_ovr_vec;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= EMPTY;
            r_rr    <= '0;
            r_ch    <= '0;
        end else if (w_load) begin
            r_state <= FULL;
            r_ch    <= w_gnt;
            r_rr    <= CH_W'(wrap_inc(int'(w_gnt), N_CH));
        end else if (w_hs) begin
            r_state <= EMPTY;
        end
    end

`ifdef DB_RELEASE_EVT_EN
    logic [N_CH-1:0] r_dir;
    logic            r_rise;

    // The loaded direction is the pre-edge value, so a same-cycle edge stays pending intact.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dir  <= '0;
            r_rise <= 1'b0;
        end else begin
            r_dir <= (r_dir & ~w_qual) | (w_new & w_qual);
            if (w_load) r_rise <= r_dir[w_gnt];
        end
    end

    assign evt.evt_rise = r_rise;
`else
    assign evt.evt_rise = 1'b1;
`endif

    assign evt.evt_valid   = (r_state == FULL);
    assign evt.evt_ch      = r_ch;
    assign evt.evt_overrun = r_ovr;

endmodule

// File: tb/tb_db_scan_ctrl.sv
// Directed testbench for db_scan_ctrl (N_CH=4, TICK_BITS=4, STABLE_TICKS=3, default build).
module tb_db_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] sw = 4'b0000;
    logic [3:0] db;

    db_evt_if #(.N_CH(4)) evt ();

    db_scan_ctrl #(
        .N_CH        (4),
        .TICK_BITS   (4),
        .STABLE_TICKS(3)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .sw     (sw),
        .db     (db),
        .evt    (evt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int vld_cyc = 0;
    int hs_cnt[4];

    // Event monitor, sampled mid-cycle; a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (evt.evt_overrun === 1'b1) ovr_cnt++;
        if (evt.evt_valid === 1'b1) vld_cyc++;
        if (evt.evt_valid === 1'b1 && evt.evt_ready === 1'b1) hs_cnt[evt.evt_ch]++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) step();
    endtask

    task automatic clr_mon();
        ovr_cnt = 0;
        vld_cyc = 0;
        for (int i = 0; i < 4; i++) hs_cnt[i] = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        step();
    endtask

    task automatic wait_db(input int ch, input logic val, input int maxc, output int n);
        n = 0;
        while (db[ch] !== val && n < maxc) begin
            step();
            n++;
        end
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        while (evt.evt_valid !== 1'b1 && n < maxc) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        evt.evt_ready = 1'b0;
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sw = 4'($urandom);
            step();
        end
        checks++;
        if (db !== 4'b0000) begin
            errors++;
            $display("FAIL reset_db: got %b expected 0000", db);
        end
        checks++;
        if (evt.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", evt.evt_valid);
        end
        checks++;
        if (evt.evt_overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_overrun: got %b expected 0", evt.evt_overrun);
        end
        sw = 4'b0000;
        cyc(2);
        reset_n = 1'b1;
        clr_mon();
        cyc(40);
        checks++;
        if (vld_cyc !== 0) begin
            errors++;
            $display("FAIL reset_idle_events: got %0d valid cycles expected 0", vld_cyc);
        end
        checks++;
        if (db !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle_db: got %b expected 0000", db);
        end
    endtask

    task automatic test_clean_press();
        int n;
        clr_mon();
        sw[1] = 1'b1;
        wait_db(1, 1'b1, 80, n);
        checks++;
        if (n < 35 || n > 50) begin
            errors++;
            $display("FAIL press_latency: got %0d cycles expected 35..50", n);
        end
        checks++;
        if (evt.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL press_valid_lag: got %b expected 0", evt.evt_valid);
        end
        step();
        checks++;
        if (evt.evt_valid !== 1'b1 || evt.evt_ch !== 2'd1 || evt.evt_rise !== 1'b1) begin
            errors++;
            $display("FAIL press_event: got v=%b ch=%0d r=%b expected v=1 ch=1 r=1",
                     evt.evt_valid, evt.evt_ch, evt.evt_rise);
        end
        evt.evt_ready = 1'b1;
        step();
        evt.evt_ready = 1'b0;
        checks++;
        if (evt.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL press_accept: got valid=%b expected 0", evt.evt_valid);
        end
        checks++;
        if (hs_cnt[1] !== 1 || ovr_cnt !== 0) begin
            errors++;
            $display("FAIL press_counts: got hs=%0d ovr=%0d expected hs=1 ovr=0", hs_cnt[1], ovr_cnt);
        end
        sw[1] = 1'b0;
        wait_db(1, 1'b0, 80, n);
        cyc(5);
        checks++;
        if (n < 35 || n > 50 || evt.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_no_event: got n=%0d valid=%b expected n=35..50 valid=0",
                     n, evt.evt_valid);
        end
    endtask

    task automatic test_bounce();
        clr_mon();
        for (int i = 0; i < 12; i++) begin
            sw[0] = ~sw[0];
            cyc(5);
        end
        cyc(60);
        checks++;
        if (db[0] !== 1'b0) begin
            errors++;
            $display("FAIL bounce_db: got %b expected 0", db[0]);
        end
        checks++;
        if (vld_cyc !== 0 || ovr_cnt !== 0) begin
            errors++;
            $display("FAIL bounce_events: got valid=%0d ovr=%0d expected 0 0", vld_cyc, ovr_cnt);
        end
    endtask

    task automatic test_arbitration();
        int n;
        int bad;
        do_reset();
        clr_mon();
        sw = 4'b1001;
        wait_valid(80, n);
        checks++;
        if (evt.evt_valid !== 1'b1 || evt.evt_ch !== 2'd0) begin
            errors++;
            $display("FAIL arb_first: got v=%b ch=%0d expected v=1 ch=0", evt.evt_valid, evt.evt_ch);
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (evt.evt_valid !== 1'b1 || evt.evt_ch !== 2'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL arb_hold: got %0d unstable cycles expected 0", bad);
        end
        evt.evt_ready = 1'b1;
        step();
        checks++;
        if (evt.evt_valid !== 1'b1 || evt.evt_ch !== 2'd3) begin
            errors++;
            $display("FAIL arb_b2b: got v=%b ch=%0d expected v=1 ch=3", evt.evt_valid, evt.evt_ch);
        end
        step();
        evt.evt_ready = 1'b0;
        checks++;
        if (evt.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL arb_drain: got valid=%b expected 0", evt.evt_valid);
        end
        checks++;
        if (hs_cnt[0] !== 1 || hs_cnt[3] !== 1 || ovr_cnt !== 0) begin
            errors++;
            $display("FAIL arb_counts: got h0=%0d h3=%0d ovr=%0d expected 1 1 0",
                     hs_cnt[0], hs_cnt[3], ovr_cnt);
        end
        sw = 4'b0000;
        cyc(60);
        checks++;
        if (db !== 4'b0000 || evt.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL arb_release: got db=%b valid=%b expected 0000 0", db, evt.evt_valid);
        end
    endtask

    task automatic test_overrun();
        int n;
        do_reset();
        clr_mon();
        evt.evt_ready = 1'b0;
        sw[0] = 1'b1;
        wait_valid(80, n);
        sw[2] = 1'b1;
        wait_db(2, 1'b1, 80, n);
        checks++;
        if (n >= 80 || evt.evt_overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first_press: got n=%0d ovr=%b expected n<80 ovr=0", n, evt.evt_overrun);
        end
        sw[2] = 1'b0;
        wait_db(2, 1'b0, 80, n);
        checks++;
        if (n >= 80 || evt.evt_overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_release: got n=%0d ovr=%b expected n<80 ovr=0", n, evt.evt_overrun);
        end
        sw[2] = 1'b1;
        wait_db(2, 1'b1, 80, n);
        checks++;
        if (evt.evt_overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_pulse: got %b expected 1", evt.evt_overrun);
        end
        step();
        checks++;
        if (evt.evt_overrun !== 1'b0 || ovr_cnt !== 1) begin
            errors++;
            $display("FAIL ovr_once: got ovr=%b count=%0d expected 0 1", evt.evt_overrun, ovr_cnt);
        end
        evt.evt_ready = 1'b1;
        cyc(4);
        evt.evt_ready = 1'b0;
        checks++;
        if (hs_cnt[0] !== 1 || hs_cnt[2] !== 1 || evt.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_delivery: got h0=%0d h2=%0d valid=%b expected 1 1 0",
                     hs_cnt[0], hs_cnt[2], evt.evt_valid);
        end
        sw = 4'b0000;
        cyc(60);
    endtask

    task automatic test_reset_mid_debounce();
        int n;
        do_reset();
        clr_mon();
        evt.evt_ready = 1'b1;
        sw[1] = 1'b1;
        n = 0;
        while (dut.g_ch[1].u_chan.r_cnt !== 2'd2 && n < 80) begin
            step();
            n++;
        end
        checks++;
        if (n >= 80) begin
            errors++;
            $display("FAIL mid_reach_cnt2: got timeout after %0d cycles expected cnt=2", n);
        end
        reset_n = 1'b0;
        step();
        checks++;
        if (db !== 4'b0000 || evt.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_cleared: got db=%b valid=%b expected 0000 0", db, evt.evt_valid);
        end
        step();
        reset_n = 1'b1;
        wait_db(1, 1'b1, 80, n);
        checks++;
        if (n < 35 || n > 50) begin
            errors++;
            $display("FAIL mid_full_debounce: got %0d cycles expected 35..50", n);
        end
        cyc(10);
        evt.evt_ready = 1'b0;
        checks++;
        if (hs_cnt[1] !== 1 || hs_cnt[0] !== 0 || hs_cnt[2] !== 0 || hs_cnt[3] !== 0) begin
            errors++;
            $display("FAIL mid_one_event: got h0=%0d h1=%0d h2=%0d h3=%0d expected 0 1 0 0",
                     hs_cnt[0], hs_cnt[1], hs_cnt[2], hs_cnt[3]);
        end
        sw = 4'b0000;
    endtask

    initial begin
        evt.evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) hs_cnt[i] = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_arbitration();
        test_overrun();
        test_reset_mid_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/db_scan_ctrl.md
# db_scan_ctrl

Multi-channel debounce controller that shares one tick prescaler across `N_CH` raw switch inputs. It keeps a debounced level per channel and queues debounced edge events as pending flags. A round-robin arbiter serialises those events onto a single valid/ready event port. It sits between the board switch pins and the system event consumer (UI FSM / bus bridge).

## Interface
- `N_CH`, 4: number of switch channels (2..16).
- `TICK_BITS`, 20: prescaler width; sample tick period = 2^TICK_BITS clk cycles (≈10.5 ms at 100 MHz).
- `STABLE_TICKS`, 3: consecutive ticks a mismatch must persist before `db` flips (1..7).
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `sw` in N_CH: raw asynchronous switch inputs.
- `db` out N_CH: debounced levels.
- `evt_valid` out 1: event available.
- `evt_ready` in 1: consumer accepts the event when `evt_valid && evt_ready` at a rising edge.
- `evt_ch` out $clog2(N_CH): channel index of the event.
- `evt_rise` out 1: 1 = press (0→1), 0 = release.
- `evt_overrun` out 1: one-cycle pulse when a new edge hits a channel whose event is still pending.

## Operation
- **Reset.** All outputs are 0. Prescaler, synchronisers, counters, pending flags and the round-robin pointer are all 0.
- **Synchroniser.** Each `sw` bit passes through 2 flops. The resulting signal is `s[i]`.
- **Prescaler.** A free-running `TICK_BITS` counter. `tick` = 1 for the single cycle when count == 2^TICK_BITS−1; the counter then wraps to 0.
- **Channel counter.** Each channel has a counter `cnt` of width $clog2(STABLE_TICKS+1).
  - If `s[i] == db[i]`: `cnt` ← 0 in every cycle, whether or not `tick` is high.
  - Else, on `tick`: `cnt` ← `cnt`+1.
  - When `cnt == STABLE_TICKS−1 && tick && s[i] != db[i]`:
    - `db[i]` ← `s[i]`;
    - `cnt` ← 0;
    - a qualifying edge is raised.
  - The mismatch must therefore span between STABLE_TICKS−1 and STABLE_TICKS tick periods.
- **Pending flags.** A qualifying edge sets `pend[i]` = 1 and `dir[i]` = new `db[i]`.
  - If `pend[i]` is already 1 and that event is not being loaded this cycle: `evt_overrun` pulses, `dir[i]` is overwritten, and one event remains pending.
- **Output slot.** Two states:
  - EMPTY (`evt_valid` = 0): if any `pend` is set, load the first set channel at or after pointer `rr`, scanning upward and wrapping at N_CH−1 → 0. Clear that `pend` bit, set `rr` ← granted+1 (mod N_CH), go to FULL.
  - FULL (`evt_valid` = 1): `evt_ch` and `evt_rise` are held constant.
    - On handshake with another flag pending: reload in the same cycle (back-to-back) and stay FULL.
    - On handshake with no flag pending: go to EMPTY.
- **Same-cycle load and edge.** A qualifying edge on the channel being loaded in the same cycle sets `pend` again. The loaded event leaves, the new one stays pending, and no overrun is flagged.
- **Reset mid-operation.** Everything clears immediately. In-flight debounce and pending events are discarded.

## Timing
- `sw` change to `s` change: 2 cycles.
- Flip condition in cycle t: `db` and `pend` update at edge t+1. `evt_valid` rises at edge t+2 if the slot was EMPTY.
- Handshake at edge t: the next event is valid from t (after the edge) with no bubble.
- `evt_overrun` is registered and asserts at the same edge that updates `db`.

## Configuration
- `DB_RELEASE_EVT_EN` defined:
  - both rising and falling debounced edges are qualifying edges;
  - `evt_rise` reflects `dir`.
- `DB_RELEASE_EVT_EN` undefined:
  - only rising edges are qualifying; release edges still update `db` but raise no `pend` and no overrun;
  - `evt_rise` is constant 1 and the `dir` storage is removed.

## Structure
- Package `db_pkg`: default constants `DB_TICK_BITS` = 20 and `DB_STABLE_TICKS` = 3, plus the typedef `slot_state_t` {EMPTY, FULL}.
- Sub-module `db_chan`: synchroniser, counter and `db` flop for one channel. Inputs: `tick`, `sw`. Outputs: `db`, edge strobe. Instantiated N_CH times in a generate loop.
- Prescaler, pending flags, arbiter and output slot live in the top level.

## Test plan
All scenarios use `N_CH`=4, `TICK_BITS`=4 (tick every 16 cycles) and `STABLE_TICKS`=3.
1. **Reset.** Hold `reset_n`=0 with random `sw` → `db`=0, `evt_valid`=0, `evt_overrun`=0. Release → no event for 40 cycles while `sw`=0.
2. **Clean press.** Raise `sw[1]` and hold → `db[1]`=1 after 2–3 ticks past sync; then `evt_valid`=1 with `evt_ch`=1, `evt_rise`=1. Pulse `evt_ready` for 1 cycle → `evt_valid`=0.
3. **Bounce.** Toggle `sw[0]` every 5 cycles for 60 cycles, then hold 0 → `db[0]` stays 0 and no event.
4. **Arbitration.** Press `sw[0]` and `sw[3]` in the same cycle with `evt_ready`=0 for 50 cycles → `evt_ch`=0 held stable. Then `evt_ready`=1 → `evt_ch`=3 on the next cycle, then `evt_valid`=0.
5. **Overrun.** With `evt_ready`=0, press `sw[2]`, release, press again (macro off) → `evt_overrun` pulses once and exactly one ch 2 event is delivered. With macro on, the release itself causes the overrun and the delivered `evt_rise` = latest direction.
6. **Reset mid-debounce.** Assert `reset_n`=0 while `cnt[1]`=2, then release with `sw[1]` still high → `db[1]`=1 only after a full new debounce, with exactly one event.
